sdes_decrypt_core: RTL

Iterative SDES decryption engine: the inverse-direction counterpart of the encrypt datapath. It accepts an 8-bit ciphertext and 10-bit key over a valid/ready handshake. It runs IP, then fK with K2, then SW, then fK with K1, then IP^-1 over several cycles, and returns the 8-bit plaintext over a second valid/ready handshake. It sits between the DE1-SoC input capture logic and the display/output path.

---
 rtl/sdes_decrypt_core.sv | 105 ++++++++++
 1 files changed

// File: rtl/sdes_decrypt_core.sv
// sdes_decrypt_core: iterative SDES decryption engine.
// Takes a ciphertext and key over one valid/ready handshake and returns the plaintext over a second one.
module sdes_decrypt_core #(
  parameter bit CLEAR_KEY = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  input  logic [9:0] i_key,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [7:0] o_data,
  output logic       o_busy
);
  typedef enum logic [2:0] {IDLE, KEYGEN, RND_K2, RND_K1, DONE} state_t;
  // Each S-box is stored row 0 first, with column 0 first inside a row, two bits per entry.
  localparam logic [31:0] S0 = {8'b01001110, 8'b11100100, 8'b00100111, 8'b11011110};
  localparam logic [31:0] S1 = {8'b00011011, 8'b10000111, 8'b11000100, 8'b10010011};
  state_t state, state_nx;
  logic [9:0] key;
  logic [9:0] pk;
  logic [7:0] k1, k2;
  logic [3:0] l, r;
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction
  function automatic logic [7:0] ip(input logic [7:0] d);
    return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
  endfunction
  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
  endfunction
  function automatic logic [1:0] sbox(input logic [31:0] t, input logic [3:0] b);
    logic [3:0] i;
    i = ~{b[3], b[0], b[2], b[1]};
    return t[{i, 1'b0} +: 2];
  endfunction
  function automatic logic [3:0] fmix(input logic [3:0] h, input logic [7:0] k);
    logic [7:0] x;
    logic [3:0] s;
    x = {h[0], h[3], h[2], h[1], h[2], h[1], h[0], h[3]} ^ k;
    s = {sbox(S0, x[7:4]), sbox(S1, x[3:0])};
    return {s[2], s[0], s[1], s[3]};
  endfunction
  // Both subkeys read straight from P10(key): the LS1/LS3 rotations are folded into the P8 picks.
  assign pk = p10(key);
  assign o_ready = (state == IDLE);
  assign o_busy = (state != IDLE);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_valid ? KEYGEN : IDLE;
      KEYGEN:  state_nx = RND_K2;
      RND_K2:  state_nx = RND_K1;
      RND_K1:  state_nx = DONE;
      DONE:    state_nx = i_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_valid <= 1'b0;
      o_data <= 8'h00;
      key <= 10'h000;
      k1 <= 8'h00;
      k2 <= 8'h00;
      l <= 4'h0;
      r <= 4'h0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (i_valid) begin
          {l, r} <= ip(i_data);
          key <= i_key;
        end
        KEYGEN: begin
          k1 <= {pk[3], pk[6], pk[2], pk[5], pk[1], pk[9], pk[4], pk[0]};
          k2 <= {pk[1], pk[9], pk[0], pk[8], pk[4], pk[7], pk[2], pk[3]};
        end
        RND_K2: begin
          l <= r;
          r <= l ^ fmix(r, k2);
        end
        RND_K1: begin
          o_data <= ip_inv({l ^ fmix(r, k1), r});
          o_valid <= 1'b1;
        end
        DONE: if (i_ready) begin
          o_valid <= 1'b0;
          if (CLEAR_KEY) begin
            key <= 10'h000;
            k1 <= 8'h00;
            k2 <= 8'h00;
            l <= 4'h0;
            r <= 4'h0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
